// File: rtl/fwd_pipe_pkg.sv
// fwd_pipe_pkg: shared slot record and selector encoding
// for the forwarding / interlock controller.
package fwd_pipe_pkg;

  localparam int REGW_MAX = 8;
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [REGW_MAX-1:0] dest;
    logic                wr;
    logic                load;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  function automatic int selOf(int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_pipe_ctrl_if.sv
// fwd_pipe_ctrl_if: decode/result inputs and forwarding,
// stall and writeback outputs of the pipe controller.
interface fwd_pipe_ctrl_if #(
  parameter int DEPTH = 3,
  parameter int DATAW = 32,
  parameter int REGW  = 5
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic                   issue_i;
  logic [REGW-1:0]        rs_i;
  logic [REGW-1:0]        rt_i;
  logic [DATAW-1:0]       rf_a_i;
  logic [DATAW-1:0]       rf_b_i;
  logic [REGW-1:0]        dest_i;
  logic                   wr_i;
  logic                   load_i;
  logic [DEPTH*DATAW-1:0] res_i;
  logic                   busy_i;
  logic                   flush_i;
  logic [DATAW-1:0]       opa_o;
  logic [DATAW-1:0]       opb_o;
  logic [SELW-1:0]        sel_a_o;
  logic [SELW-1:0]        sel_b_o;
  logic                   stall_d_o;
  logic                   wb_valid_o;
  logic [REGW-1:0]        wb_reg_o;
  logic [31:0]            stall_cnt_o;

  modport master (
    output issue_i, rs_i, rt_i, rf_a_i, rf_b_i,
    output dest_i, wr_i, load_i, res_i,
    output busy_i, flush_i,
    input  opa_o, opb_o, sel_a_o, sel_b_o,
    input  stall_d_o, wb_valid_o, wb_reg_o,
    input  stall_cnt_o
  );

  modport slave (
    input  issue_i, rs_i, rt_i, rf_a_i, rf_b_i,
    input  dest_i, wr_i, load_i, res_i,
    input  busy_i, flush_i,
    output opa_o, opb_o, sel_a_o, sel_b_o,
    output stall_d_o, wb_valid_o, wb_reg_o,
    output stall_cnt_o
  );

endinterface

// File: rtl/fwd_match.sv
// fwd_match: youngest-match search for one source operand.
// FWD_PIPE_BYPASS_EN selects forwarding, else interlock-only.
module fwd_match
  import fwd_pipe_pkg::*;
#(
  parameter  int DEPTH   = 3,
  parameter  int DATAW   = 32,
  parameter  int REGW    = 5,
  parameter  int LOADSTG = DEPTH - 1,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  slot_t [DEPTH-1:0]      slots,
  input  logic [REGW-1:0]        src,
  input  logic [DATAW-1:0]       rf,
  input  logic [DEPTH*DATAW-1:0] res,
  output logic [DATAW-1:0]       opnd,
  output logic [SELW-1:0]        sel,
  output logic                   hold
);

  logic found;
  int   idx;

  // lowest slot index is the youngest producer
  always_comb begin
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && src != '0 &&
          slots[k].valid && slots[k].wr &&
          slots[k].dest == REGW_MAX'(src)) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

`ifdef FWD_PIPE_BYPASS_EN
  always_comb begin
    opnd = rf;
    sel  = SELW'(SEL_RF);
    hold = 1'b0;
    if (found) begin
      if (slots[idx].load && idx < LOADSTG) begin
        hold = 1'b1;
      end else begin
        sel  = SELW'(selOf(idx));
        opnd = res[idx*DATAW +: DATAW];
      end
    end
  end
`else
  logic unusedBits;
  assign unusedBits = ^{res, slots} ^ (LOADSTG > 0);
  assign opnd = rf;
  assign sel  = SELW'(SEL_RF);
  // the last slot writes the regfile this cycle
  assign hold = found && (idx < DEPTH - 1);
`endif

endmodule

// File: rtl/fwd_pipe_ctrl.sv
// fwd_pipe_ctrl: slot tracking, forwarding and stall control.
// Define FWD_PIPE_BYPASS_EN to enable result forwarding.
module fwd_pipe_ctrl
  import fwd_pipe_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int DATAW   = 32,
  parameter int REGW    = 5,
  parameter int LOADSTG = DEPTH - 1
) (
  input logic             clk,
  input logic             rst,
  fwd_pipe_ctrl_if.slave  bus
);

  localparam int SELW = $clog2(DEPTH + 1);

  slot_t [DEPTH-1:0] slotQ;
  slot_t             entry;
  logic              holdA;
  logic              holdB;
  logic              stallD;
  logic [31:0]       stallCnt;
  logic [DATAW-1:0]  opA;
  logic [DATAW-1:0]  opB;
  logic [SELW-1:0]   selA;
  logic [SELW-1:0]   selB;

  fwd_match #(
    .DEPTH(DEPTH), .DATAW(DATAW),
    .REGW(REGW), .LOADSTG(LOADSTG)
  ) uMatchA (
    .slots(slotQ), .src(bus.rs_i),
    .rf(bus.rf_a_i), .res(bus.res_i),
    .opnd(opA), .sel(selA), .hold(holdA)
  );

  fwd_match #(
    .DEPTH(DEPTH), .DATAW(DATAW),
    .REGW(REGW), .LOADSTG(LOADSTG)
  ) uMatchB (
    .slots(slotQ), .src(bus.rt_i),
    .rf(bus.rf_b_i), .res(bus.res_i),
    .opnd(opB), .sel(selB), .hold(holdB)
  );

  assign entry = '{
    valid: bus.issue_i,
    dest:  REGW_MAX'(bus.dest_i),
    wr:    bus.wr_i,
    load:  bus.load_i
  };

  assign stallD = ~rst & bus.issue_i & ~bus.flush_i &
                  (bus.busy_i | holdA | holdB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotQ    <= '0;
      stallCnt <= '0;
    end else begin
      for (int k = 2; k < DEPTH; k++) begin
        slotQ[k] <= slotQ[k-1];
      end
      // flush kills slot 0 even while the unit is busy
      if (bus.flush_i) begin
        slotQ[0] <= BUBBLE;
        slotQ[1] <= BUBBLE;
      end else if (bus.busy_i) begin
        slotQ[1] <= BUBBLE;
      end else begin
        slotQ[1] <= slotQ[0];
        slotQ[0] <= stallD ? BUBBLE : entry;
      end
      if (stallD && stallCnt != '1) begin
        stallCnt <= stallCnt + 32'd1;
      end
    end
  end

  assign bus.opa_o       = opA;
  assign bus.opb_o       = opB;
  assign bus.sel_a_o     = selA;
  assign bus.sel_b_o     = selB;
  assign bus.stall_d_o   = stallD;
  assign bus.stall_cnt_o = stallCnt;
  assign bus.wb_valid_o  = slotQ[DEPTH-1].valid &
                           slotQ[DEPTH-1].wr;
  assign bus.wb_reg_o    = slotQ[DEPTH-1].dest[REGW-1:0];

endmodule

// File: tb/tb_fwd_pipe_ctrl.sv
// tb_fwd_pipe_ctrl: directed vectors plus an age-based
// pipeline model compared on every falling clock edge.
module tb_fwd_pipe_ctrl;

  localparam int D  = 3;
  localparam int W  = 32;
  localparam int R  = 5;
  localparam int LS = D - 1;
`ifdef FWD_PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_pipe_ctrl_if #(.DEPTH(D), .DATAW(W), .REGW(R)) bus ();

  fwd_pipe_ctrl #(
    .DEPTH(D), .DATAW(W), .REGW(R), .LOADSTG(LS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // model: per age, the instruction occupying it
  int mV[D];
  int mD[D];
  int mW[D];
  int mL[D];
  logic [31:0] mCnt;

  task automatic lookup(input int src, output int hz, output int sel);
    int y;
    y   = -1;
    hz  = 0;
    sel = 0;
    for (int a = D - 1; a >= 0; a--)
      if (src != 0 && mV[a] != 0 && mW[a] != 0 && mD[a] == src) y = a;
    if (BYP) begin
      if (y >= 0 && mL[y] != 0 && y < LS) hz = 1;
      else if (y >= 0) sel = y + 1;
    end else begin
      if (y >= 0 && y < D - 1) hz = 1;
    end
  endtask

  always @(negedge clk) begin
    int hA, hB, sA, sB;
    logic [W-1:0] eA, eB;
    bit eStall;
    if (rst) begin
      for (int a = 0; a < D; a++) begin
        mV[a] = 0; mD[a] = 0; mW[a] = 0; mL[a] = 0;
      end
      mCnt = 0;
      chk("rst_stall", bus.stall_d_o, 0);
      chk("rst_sel_a", bus.sel_a_o, 0);
      chk("rst_wb_valid", bus.wb_valid_o, 0);
      chk("rst_cnt", bus.stall_cnt_o, 0);
    end else begin
      lookup(int'(bus.rs_i), hA, sA);
      lookup(int'(bus.rt_i), hB, sB);
      eA = (sA == 0) ? bus.rf_a_i : bus.res_i[(sA-1)*W +: W];
      eB = (sB == 0) ? bus.rf_b_i : bus.res_i[(sB-1)*W +: W];
      eStall = bus.issue_i && !bus.flush_i &&
               (bus.busy_i || hA != 0 || hB != 0);
      chk("m_opa", bus.opa_o, eA);
      chk("m_opb", bus.opb_o, eB);
      chk("m_sel_a", bus.sel_a_o, sA);
      chk("m_sel_b", bus.sel_b_o, sB);
      chk("m_stall", bus.stall_d_o, eStall);
      chk("m_cnt", bus.stall_cnt_o, mCnt);
      chk("m_wb_valid", bus.wb_valid_o,
          (mV[D-1] != 0 && mW[D-1] != 0));
      if (mV[D-1] != 0 && mW[D-1] != 0)
        chk("m_wb_reg", bus.wb_reg_o, mD[D-1]);
      // next clock edge
      if (eStall && mCnt != 32'hFFFF_FFFF) mCnt++;
      for (int a = D - 1; a >= 2; a--) begin
        mV[a] = mV[a-1]; mD[a] = mD[a-1];
        mW[a] = mW[a-1]; mL[a] = mL[a-1];
      end
      if (bus.flush_i) begin
        mV[0] = 0; mV[1] = 0;
      end else if (bus.busy_i) begin
        mV[1] = 0;
      end else begin
        mV[1] = mV[0]; mD[1] = mD[0];
        mW[1] = mW[0]; mL[1] = mL[0];
        mV[0] = (bus.issue_i && !eStall) ? 1 : 0;
        mD[0] = int'(bus.dest_i);
        mW[0] = int'(bus.wr_i);
        mL[0] = int'(bus.load_i);
      end
    end
  end

  task automatic idle();
    bus.issue_i = 0; bus.rs_i = 0; bus.rt_i = 0;
    bus.rf_a_i = 32'hAAAA; bus.rf_b_i = 32'hBBBB;
    bus.dest_i = 0; bus.wr_i = 0; bus.load_i = 0;
    bus.res_i = {32'h2222, 32'h1111, 32'h1234};
    bus.busy_i = 0; bus.flush_i = 0;
  endtask

  task automatic instr(input bit iss, input int rs, input int rt,
                       input int dst, input bit wr, input bit ld);
    bus.issue_i = iss;
    bus.rs_i = R'(rs); bus.rt_i = R'(rt);
    bus.dest_i = R'(dst);
    bus.wr_i = wr; bus.load_i = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("reset_stall", bus.stall_d_o, 0);
    chk("reset_sel_a", bus.sel_a_o, 0);
    chk("reset_wb_valid", bus.wb_valid_o, 0);
    chk("reset_cnt", bus.stall_cnt_o, 0);

    // load-use on r8
    tick(); instr(1, 0, 0, 8, 1, 1);
    tick(); instr(1, 8, 0, 9, 1, 0);
    #1 chk("lu_stall1", bus.stall_d_o, 1);
    tick(); #1 chk("lu_stall2", bus.stall_d_o, 1);
    tick(); #1 chk("lu_stall3", bus.stall_d_o, 0);
    chk("lu_sel_a", bus.sel_a_o, BYP ? 3 : 0);
    chk("lu_opa", bus.opa_o, BYP ? 32'h2222 : 32'hAAAA);
    chk("lu_cnt", bus.stall_cnt_o, 2);
    drain(4);

    // forward from slot 0
    instr(1, 0, 0, 5, 1, 0);
    tick(); instr(1, 5, 0, 6, 1, 0);
    bus.rf_a_i = 32'hDEAD;
    #1 chk("fw_opa", bus.opa_o, BYP ? 32'h1234 : 32'hDEAD);
    chk("fw_sel_a", bus.sel_a_o, BYP ? 1 : 0);
    chk("fw_stall", bus.stall_d_o, BYP ? 0 : 1);
    tick();
    drain(4);

    // r0 never matches
    instr(1, 0, 0, 0, 1, 0);
    tick(); instr(1, 0, 0, 7, 1, 0);
    bus.rf_a_i = 0;
    #1 chk("r0_sel_a", bus.sel_a_o, 0);
    chk("r0_stall", bus.stall_d_o, 0);
    chk("r0_opa", bus.opa_o, 0);
    tick();
    drain(4);

    // busy for 4 cycles with r3 producer in slot 0
    instr(1, 0, 0, 3, 1, 0);
    tick(); instr(1, 9, 0, 10, 1, 0);
    bus.busy_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("busy_stall", bus.stall_d_o, 1);
      if (i >= 2) chk("busy_wb_valid", bus.wb_valid_o, 0);
      tick();
    end
    bus.busy_i = 0;
    tick(); idle();
    tick();
    #1 chk("busy_wb_valid_end", bus.wb_valid_o, 1);
    chk("busy_wb_reg", bus.wb_reg_o, 3);
    drain(4);

    // flush beats load-use
    instr(1, 0, 0, 8, 1, 1);
    tick(); instr(1, 8, 0, 12, 1, 0);
    bus.flush_i = 1;
    #1 chk("fl_stall", bus.stall_d_o, 0);
    tick(); bus.flush_i = 0;
    instr(1, 12, 0, 13, 1, 0);
    #1 chk("fl_sel_a", bus.sel_a_o, 0);
    chk("fl_stall_next", bus.stall_d_o, 0);
    tick();
    drain(4);

    // async reset in the middle of a load-use stall
    instr(1, 0, 0, 8, 1, 1);
    tick(); instr(1, 8, 0, 14, 1, 0);
    #1 chk("ar_pre_stall", bus.stall_d_o, 1);
    #1 rst = 1'b1;
    #1 chk("ar_stall", bus.stall_d_o, 0);
    chk("ar_cnt", bus.stall_cnt_o, 0);
    chk("ar_wb_valid", bus.wb_valid_o, 0);
    chk("ar_wb_reg", bus.wb_reg_o, 0);
    chk("ar_sel_a", bus.sel_a_o, 0);
    #3 rst = 1'b0;
    drain(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
